mcu_debug_controller: RTL and testbench

//  Run-control and debug sequencer for the 8-bit MCU core. Sits between controller_fsm and the datapath.
//  - Gates the core's load strobes and produces a core-wide enable.
//  - Provides halt, run and single-step, plus PC breakpoints and a retired-fetch counter.
//  - Host access is a valid/ready command port.

---
 rtl/mcu_dbg_pkg.sv | 29 ++
 rtl/mcu_bp_match.sv | 53 +++++
 rtl/mcu_debug_controller.sv | 198 +++++++++++++++++++
 tb/tb_mcu_debug_controller.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_dbg_pkg.sv
// Shared definitions for the MCU run-control / debug sequencer.
//   - host command opcodes carried on Cmd_op
//   - run-control FSM state encoding
//   - halt-cause codes reported on Halt_cause
package mcu_dbg_pkg;

    localparam logic [2:0] DBG_NOP      = 3'd0;
    localparam logic [2:0] DBG_HALT     = 3'd1;
    localparam logic [2:0] DBG_RUN      = 3'd2;
    localparam logic [2:0] DBG_STEP     = 3'd3;
    localparam logic [2:0] DBG_SET_BP   = 3'd4;
    localparam logic [2:0] DBG_CLR_BP   = 3'd5;
    localparam logic [2:0] DBG_READ_PC  = 3'd6;
    localparam logic [2:0] DBG_READ_CNT = 3'd7;

    typedef enum logic [2:0] {
        S_RUN,
        S_HALT_P,
        S_HALTED,
        S_STEP_F,
        S_STEP_X
    } dbg_state_e;

    localparam logic [1:0] CAUSE_RESET = 2'b00;
    localparam logic [1:0] CAUSE_HALT  = 2'b01;
    localparam logic [1:0] CAUSE_BP    = 2'b10;
    localparam logic [1:0] CAUSE_STEP  = 2'b11;

endpackage

// File: rtl/mcu_bp_match.sv
// PC breakpoint comparator bank.
//   clk_i      system clock
//   rst_ni     async active-low reset; disables every breakpoint
//   set_i      load addr_i into entry sel_i and enable it
//   clr_i      disable entry sel_i
//   sel_i      entry index; indices >= NUM_BP are ignored
//   addr_i     breakpoint address for set_i
//   pc_i       PC of the instruction about to be fetched
//   bp_hit_o   some enabled entry matches pc_i (uses the current, pre-write registers)
module mcu_bp_match #(
    parameter int unsigned NUM_BP = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       set_i,
    input  logic       clr_i,
    input  logic [1:0] sel_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] pc_i,
    output logic       bp_hit_o
);

    logic [NUM_BP-1:0][7:0] bp_addr_q;
    logic [NUM_BP-1:0]      bp_en_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bp_addr_q <= '0;
            bp_en_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (sel_i == 2'(i)) begin
                    if (set_i) begin
                        bp_addr_q[i] <= addr_i;
                        bp_en_q[i]   <= 1'b1;
                    end else if (clr_i) begin
                        bp_en_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        bp_hit_o = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_en_q[i] && (bp_addr_q[i] == pc_i)) begin
                bp_hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mcu_debug_controller.sv
// Run-control and debug sequencer between controller_fsm and the datapath.
// Gates the core load strobes, provides halt/run/single-step, PC breakpoints,
// a retired-fetch counter and a valid/ready host command port.
//   Clk, Reset_n                 clock, async active-low reset
//   currentPC                    PC of the instruction about to be fetched
//   Fetch_req                    controller_fsm LoadIR (fetch cycle)
//   IncPC_in..LoadAcc_in         raw controller_fsm strobes
//   Core_run                     core-wide enable; 0 freezes controller_fsm
//   LoadIR, IncPC, LoadPC,
//   LoadReg, LoadAcc             strobes gated by Core_run
//   Cmd_valid/Cmd_ready          host command handshake
//   Cmd_op, Cmd_sel, Cmd_data    opcode, breakpoint index, breakpoint address
//   Rsp_valid, Rsp_data          registered one-cycle read response
//   Halted, Halt_cause           frozen at an instruction boundary, and why
module mcu_debug_controller
    import mcu_dbg_pkg::*;
#(
    parameter int unsigned NUM_BP    = 2,
    parameter bit          RESET_RUN = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] currentPC,
    input  logic       Fetch_req,
    input  logic       IncPC_in,
    input  logic       LoadPC_in,
    input  logic       LoadReg_in,
    input  logic       LoadAcc_in,
    output logic       Core_run,
    output logic       LoadIR,
    output logic       IncPC,
    output logic       LoadPC,
    output logic       LoadReg,
    output logic       LoadAcc,
    input  logic       Cmd_valid,
    output logic       Cmd_ready,
    input  logic [2:0] Cmd_op,
    input  logic [1:0] Cmd_sel,
    input  logic [7:0] Cmd_data,
    output logic       Rsp_valid,
    output logic [7:0] Rsp_data,
    output logic       Halted,
    output logic [1:0] Halt_cause
);

    localparam dbg_state_e RESET_STATE = RESET_RUN ? S_RUN : S_HALTED;

    dbg_state_e state_q, state_d;
    logic [1:0] cause_q, cause_d;
    logic       skip_q, skip_d;
    logic [7:0] count_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_data_q;
    logic       accept;
    logic       bp_hit;
    logic       bp_stop;

    assign accept = Cmd_valid & Cmd_ready;
    // skip masks the breakpoint we just resumed from, for the first fetch only
    assign bp_stop = Fetch_req & bp_hit & ~skip_q;

    mcu_bp_match #(
        .NUM_BP (NUM_BP)
    ) u_bp_match (
        .clk_i    (Clk),
        .rst_ni   (Reset_n),
        .set_i    (accept && (Cmd_op == DBG_SET_BP)),
        .clr_i    (accept && (Cmd_op == DBG_CLR_BP)),
        .sel_i    (Cmd_sel),
        .addr_i   (Cmd_data),
        .pc_i     (currentPC),
        .bp_hit_o (bp_hit)
    );

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= RESET_STATE;
            cause_q <= CAUSE_RESET;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            skip_q  <= skip_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        skip_d  = skip_q;
        case (state_q)
            S_RUN: begin
                if (Fetch_req) begin
                    skip_d = 1'b0;
                end
                // a breakpoint hit takes priority over a HALT in the same cycle
                if (bp_stop) begin
                    state_d = S_HALTED;
                    cause_d = CAUSE_BP;
                end else if (accept && (Cmd_op == DBG_HALT)) begin
                    state_d = S_HALT_P;
                end
            end
            S_HALT_P: begin
                if (Fetch_req) begin
                    state_d = S_HALTED;
                    cause_d = CAUSE_HALT;
                end
            end
            S_HALTED: begin
                if (accept && (Cmd_op == DBG_RUN)) begin
                    state_d = S_RUN;
                    skip_d  = 1'b1;
                end else if (accept && (Cmd_op == DBG_STEP)) begin
                    state_d = S_STEP_F;
                end
            end
            S_STEP_F: begin
                if (Fetch_req) begin
                    state_d = S_STEP_X;
                end
            end
            S_STEP_X: begin
                if (Fetch_req) begin
                    state_d = S_HALTED;
                    cause_d = CAUSE_STEP;
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // Output logic; freezing only ever happens on a fetch cycle
    always_comb begin
        Core_run  = 1'b1;
        Cmd_ready = 1'b1;
        case (state_q)
            S_RUN: begin
                Core_run = ~bp_stop;
            end
            S_HALT_P, S_STEP_X: begin
                Core_run  = ~Fetch_req;
                Cmd_ready = 1'b0;
            end
            S_STEP_F: begin
                Cmd_ready = 1'b0;
            end
            S_HALTED: begin
                Core_run = 1'b0;
            end
            default: begin
                Core_run = 1'b0;
            end
        endcase
    end

    assign Halted     = (state_q == S_HALTED);
    assign Halt_cause = cause_q;

    assign LoadIR  = Fetch_req  & Core_run;
    assign IncPC   = IncPC_in   & Core_run;
    assign LoadPC  = LoadPC_in  & Core_run;
    assign LoadReg = LoadReg_in & Core_run;
    assign LoadAcc = LoadAcc_in & Core_run;

    // Retired-fetch counter, wraps naturally at 8 bits
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q <= 8'h00;
        end else if (LoadIR) begin
            count_q <= count_q + 8'd1;
        end
    end

    // Read response; READ_CNT captures the pre-increment count
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else if (accept && (Cmd_op == DBG_READ_PC)) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= currentPC;
        end else if (accept && (Cmd_op == DBG_READ_CNT)) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= count_q;
        end else begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign Rsp_valid = rsp_valid_q;
    assign Rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mcu_debug_controller.sv
// Bench for mcu_debug_controller: a small core emulator supplies Fetch_req/currentPC,
// directed host commands drive run control, and read responses are scoreboarded.
module tb_mcu_debug_controller;
    import mcu_dbg_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [7:0] currentPC;
    logic       Fetch_req;
    logic       IncPC_in, LoadPC_in, LoadReg_in, LoadAcc_in;
    logic       Core_run, LoadIR, IncPC, LoadPC, LoadReg, LoadAcc;
    logic       Cmd_valid;
    logic       Cmd_ready;
    logic [2:0] Cmd_op;
    logic [1:0] Cmd_sel;
    logic [7:0] Cmd_data;
    logic       Rsp_valid;
    logic [7:0] Rsp_data;
    logic       Halted;
    logic [1:0] Halt_cause;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] sb_q[$];

    // core emulator state
    logic [7:0] pc;
    logic [1:0] phase;
    logic       core_go;
    logic       pc_load;
    logic [7:0] pc_load_val;
    logic       force_strobes;

    always #5 Clk = ~Clk;

    mcu_debug_controller #(
        .NUM_BP    (2),
        .RESET_RUN (1'b1)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .currentPC  (currentPC),
        .Fetch_req  (Fetch_req),
        .IncPC_in   (IncPC_in),
        .LoadPC_in  (LoadPC_in),
        .LoadReg_in (LoadReg_in),
        .LoadAcc_in (LoadAcc_in),
        .Core_run   (Core_run),
        .LoadIR     (LoadIR),
        .IncPC      (IncPC),
        .LoadPC     (LoadPC),
        .LoadReg    (LoadReg),
        .LoadAcc    (LoadAcc),
        .Cmd_valid  (Cmd_valid),
        .Cmd_ready  (Cmd_ready),
        .Cmd_op     (Cmd_op),
        .Cmd_sel    (Cmd_sel),
        .Cmd_data   (Cmd_data),
        .Rsp_valid  (Rsp_valid),
        .Rsp_data   (Rsp_data),
        .Halted     (Halted),
        .Halt_cause (Halt_cause)
    );

    // 4-phase core: phase 0 is the fetch cycle; phases advance only while Core_run
    assign currentPC  = pc;
    assign Fetch_req  = core_go && (phase == 2'd0);
    assign IncPC_in   = force_strobes || (core_go && (phase == 2'd1));
    assign LoadPC_in  = force_strobes;
    assign LoadReg_in = force_strobes || (core_go && (phase == 2'd2));
    assign LoadAcc_in = force_strobes || (core_go && (phase == 2'd3));

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc    <= 8'h00;
            phase <= 2'd0;
        end else begin
            if (pc_load) begin
                pc <= pc_load_val;
            end else if (LoadIR) begin
                pc <= pc + 8'd1;
            end
            if (pc_load) begin
                phase <= 2'd0;
            end else if (Core_run && core_go) begin
                phase <= phase + 2'd1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // response monitor
    always @(negedge Clk) begin : monitor
        logic [7:0] exp_v;
        if (Reset_n && Rsp_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL rsp_unexpected: got 0x%0h, required no response", Rsp_data);
            end else begin
                exp_v = sb_q.pop_front();
                check("rsp_data", int'(Rsp_data), int'(exp_v));
            end
        end
    end

    // Called between negedge and posedge; returns at negedge+1 after acceptance.
    task automatic send(input logic [2:0] op, input logic [1:0] sel, input logic [7:0] data);
        int cyc = 0;
        Cmd_valid = 1'b1;
        Cmd_op    = op;
        Cmd_sel   = sel;
        Cmd_data  = data;
        while (!Cmd_ready && cyc < 50) begin
            @(negedge Clk);
            #1;
            cyc++;
        end
        if (!Cmd_ready) begin
            n_checks++;
            $display("FAIL cmd_timeout: Cmd_ready got 0, required 1");
        end
        @(negedge Clk);
        #1;
        Cmd_valid = 1'b0;
        Cmd_op    = DBG_NOP;
    endtask

    task automatic read(input logic [2:0] op, input logic [7:0] exp);
        sb_q.push_back(exp);
        send(op, 2'd0, 8'h00);
    endtask

    task automatic run_fetches(input int n);
        int k = 0;
        int cyc = 0;
        core_go = 1'b1;
        while (k < n && cyc < 8 * n + 20) begin
            #1;
            if (LoadIR) k++;
            @(negedge Clk);
            cyc++;
        end
        #1;
        core_go = 1'b0;
        if (k < n) begin
            n_checks++;
            $display("FAIL fetch_timeout: got %0d fetches, required %0d", k, n);
        end
    endtask

    // Leaves core_go=1 at negedge+1 with Fetch_req asserted.
    task automatic wait_fetch();
        int cyc = 0;
        core_go = 1'b1;
        #1;
        while (!Fetch_req && cyc < 20) begin
            @(negedge Clk);
            #1;
            cyc++;
        end
        if (!Fetch_req) begin
            n_checks++;
            $display("FAIL fetch_wait_timeout: Fetch_req got 0, required 1");
        end
    endtask

    task automatic run_until_halt(output int fetched);
        int cyc = 0;
        fetched = 0;
        core_go = 1'b1;
        #1;
        while (!Halted && cyc < 200) begin
            if (LoadIR) fetched++;
            @(negedge Clk);
            #1;
            cyc++;
        end
        core_go = 1'b0;
        if (!Halted) begin
            n_checks++;
            $display("FAIL halt_timeout: Halted got 0, required 1");
        end
    endtask

    task automatic set_pc(input logic [7:0] v);
        pc_load     = 1'b1;
        pc_load_val = v;
        @(negedge Clk);
        #1;
        pc_load = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  fetched;
        bit  step_ok;
        Reset_n       = 1'b1;
        core_go       = 1'b0;
        pc_load       = 1'b0;
        pc_load_val   = 8'h00;
        force_strobes = 1'b0;
        Cmd_valid     = 1'b0;
        Cmd_op        = DBG_NOP;
        Cmd_sel       = 2'd0;
        Cmd_data      = 8'h00;
        #1 Reset_n = 1'b0;
        #1;
        check("rst_halted", int'(Halted), 0);
        check("rst_cause", int'(Halt_cause), 0);
        check("rst_core_run", int'(Core_run), 1);
        check("rst_cmd_ready", int'(Cmd_ready), 1);
        check("rst_rsp_valid", int'(Rsp_valid), 0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;

        // 1: free run, three fetches from PC 0
        run_fetches(3);
        check("t1_halted", int'(Halted), 0);
        check("t1_core_run", int'(Core_run), 1);
        force_strobes = 1'b1;
        #1;
        check("t1_strobes_pass", int'({IncPC, LoadPC, LoadReg, LoadAcc}), 4'hF);
        force_strobes = 1'b0;
        read(DBG_READ_CNT, 8'h03);
        read(DBG_READ_PC, 8'h03);

        // 2: breakpoint at 0x05
        send(DBG_SET_BP, 2'd0, 8'h05);
        set_pc(8'h00);
        run_fetches(5);
        wait_fetch();
        check("t2_pc", int'(currentPC), 8'h05);
        check("t2_loadir_blocked", int'(LoadIR), 0);
        check("t2_core_run", int'(Core_run), 0);
        @(negedge Clk);
        #1;
        core_go = 1'b0;
        check("t2_halted", int'(Halted), 1);
        check("t2_cause", int'(Halt_cause), 2);
        force_strobes = 1'b1;
        #1;
        check("t2_strobes_gated", int'({IncPC, LoadPC, LoadReg, LoadAcc}), 4'h0);
        force_strobes = 1'b0;
        read(DBG_READ_PC, 8'h05);
        read(DBG_READ_CNT, 8'h08);

        // 3: resume; the fetch at 0x05 proceeds
        send(DBG_RUN, 2'd0, 8'h00);
        wait_fetch();
        check("t3_skip_fetch", int'(LoadIR), 1);
        @(negedge Clk);
        #1;
        core_go = 1'b0;
        check("t3_halted", int'(Halted), 0);
        check("t3_pc", int'(currentPC), 8'h06);
        read(DBG_READ_CNT, 8'h09);

        // 4: halt at 0x10, then single step
        send(DBG_SET_BP, 2'd1, 8'h10);
        run_until_halt(fetched);
        check("t4_fetches_to_bp", fetched, 10);
        check("t4_cause_bp", int'(Halt_cause), 2);
        check("t4_pc_bp", int'(currentPC), 8'h10);
        send(DBG_STEP, 2'd0, 8'h00);
        fetched = 0;
        step_ok = 1'b1;
        core_go = 1'b1;
        #1;
        for (int c = 0; c < 30; c++) begin
            if (Halted) break;
            if (Cmd_ready) step_ok = 1'b0;
            if (LoadIR) fetched++;
            @(negedge Clk);
            #1;
        end
        core_go = 1'b0;
        check("t4_ready_low_in_step", int'(step_ok), 1);
        check("t4_step_fetches", fetched, 1);
        check("t4_step_halted", int'(Halted), 1);
        check("t4_step_cause", int'(Halt_cause), 3);
        check("t4_step_pc", int'(currentPC), 8'h11);
        read(DBG_READ_CNT, 8'h14);

        // 5a: HALT accepted in the breakpoint-hit cycle
        send(DBG_SET_BP, 2'd0, 8'h14);
        send(DBG_RUN, 2'd0, 8'h00);
        run_fetches(3);
        wait_fetch();
        check("t5_hit_pc", int'(currentPC), 8'h14);
        check("t5_hit_loadir", int'(LoadIR), 0);
        Cmd_valid = 1'b1;
        Cmd_op    = DBG_HALT;
        @(negedge Clk);
        #1;
        Cmd_valid = 1'b0;
        Cmd_op    = DBG_NOP;
        core_go   = 1'b0;
        check("t5_halted", int'(Halted), 1);
        check("t5_cause_bp_wins", int'(Halt_cause), 2);
        check("t5_not_halt_pending", int'(Cmd_ready), 1);

        // 5b: out-of-range breakpoint index ignored; counter wrap
        send(DBG_CLR_BP, 2'd0, 8'h00);
        send(DBG_CLR_BP, 2'd1, 8'h00);
        send(DBG_SET_BP, 2'd2, 8'h20);
        send(DBG_SET_BP, 2'd3, 8'h30);
        read(DBG_READ_PC, 8'h14);
        send(DBG_RUN, 2'd0, 8'h00);
        run_fetches(232);
        check("t5_no_halt_sel_ignored", int'(Halted), 0);
        read(DBG_READ_CNT, 8'hFF);
        wait_fetch();
        read(DBG_READ_CNT, 8'hFF);
        core_go = 1'b0;
        read(DBG_READ_CNT, 8'h00);

        // 6: reset during STEP_X
        send(DBG_SET_BP, 2'd0, 8'h40);
        send(DBG_HALT, 2'd0, 8'h00);
        check("t6_halt_pending_ready", int'(Cmd_ready), 0);
        run_until_halt(fetched);
        check("t6_halt_fetches", fetched, 0);
        check("t6_cause_halt", int'(Halt_cause), 1);
        send(DBG_STEP, 2'd0, 8'h00);
        run_fetches(1);
        check("t6_step_x_ready", int'(Cmd_ready), 0);
        Cmd_valid = 1'b1;
        Cmd_op    = DBG_READ_PC;
        Reset_n   = 1'b0;
        #1;
        check("t6_rst_halted", int'(Halted), 0);
        check("t6_rst_cause", int'(Halt_cause), 0);
        check("t6_rst_core_run", int'(Core_run), 1);
        check("t6_rst_ready", int'(Cmd_ready), 1);
        check("t6_rst_rsp_valid", int'(Rsp_valid), 0);
        check("t6_rst_rsp_data", int'(Rsp_data), 0);
        Cmd_valid = 1'b0;
        Cmd_op    = DBG_NOP;
        @(negedge Clk);
        #1;
        Reset_n = 1'b1;
        set_pc(8'h40);
        wait_fetch();
        check("t6_bp_cleared", int'(LoadIR), 1);
        @(negedge Clk);
        #1;
        core_go = 1'b0;
        read(DBG_READ_CNT, 8'h01);

        @(negedge Clk);
        @(negedge Clk);
        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
